// File: rtl/bcd_count_display.sv
// Multi-digit BCD up/down counter with prescaler, debounced run/pause button,
// synchronous clear and a time-multiplexed seven-segment scan driver.
module bcd_count_display #(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 12000000,
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE       = 120000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn,
  input  logic                  clr,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  running,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // ---------------- button: synchroniser, debounce, rising-edge toggle
  logic            btn_meta, btn_sync;
  logic            btn_level, btn_level_d;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      btn_level   <= 1'b0;
      btn_level_d <= 1'b0;
      db_cnt      <= '0;
    end else begin
      btn_meta    <= btn;
      btn_sync    <= btn_meta;
      btn_level_d <= btn_level;
      if (btn_sync == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_level <= btn_sync;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn_level & ~btn_level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        running <= 1'b1;
    else if (press) running <= ~running;
  end

  // ---------------- prescaler and BCD counter
  logic [TICK_W-1:0]   presc;
  logic                step;
  logic [4*DIGITS-1:0] count_next;
  logic                rolled;

  assign step = running && (presc == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (running) begin
      presc <= (presc == TICK_LAST) ? '0 : presc + 1'b1;
    end
  end

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    count_next = count;
    carry      = 1'b1;
    digit      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (digit == 4'd9) count_next[4*i +: 4] = 4'd0;
          else begin
            count_next[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) count_next[4*i +: 4] = 4'd9;
          else begin
            count_next[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    // A carry out of the top digit means every digit rolled over.
    rolled = carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (step) begin
      count <= count_next;
      wrap  <= rolled;
    end else begin
      wrap  <= 1'b0;
    end
  end

  // ---------------- display scan (independent of running and clr)
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] an_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_r    <= 7'b0111111;
      an_r     <= DIGITS'(1);
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an_r  <= DIGITS'(1) << idx;
      seg_r <= decode(count[4*int'(idx) +: 4]);
    end
  end

  assign seg = seg_r ^ {7{SEG_ACTIVE_LOW}};
  assign an  = an_r ^ {DIGITS{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_bcd_count_display.sv
// Directed bench for bcd_count_display (2 digits, fast rates); a second
// instance with active-low outputs shares all stimulus.
module tb_bcd_count_display;

  logic       clk = 1'b0;
  logic       rst, btn, clr, up;
  logic [7:0] count, count_n;
  logic       wrap, wrap_n, running, running_n;
  logic [6:0] seg, seg_n;
  logic [1:0] an, an_n;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bcd_count_display #(
    .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .DEBOUNCE(5), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .clr(clr), .up(up),
    .count(count), .wrap(wrap), .running(running), .seg(seg), .an(an)
  );

  bcd_count_display #(
    .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .DEBOUNCE(5), .SEG_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .btn(btn), .clr(clr), .up(up),
    .count(count_n), .wrap(wrap_n), .running(running_n), .seg(seg_n), .an(an_n)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; btn = 1'b0; clr = 1'b0; up = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL reset_count got %h want 00", count); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b want 0", wrap); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL reset_running got %b want 1", running); end
    n_checks++; if (an !== 2'b01) begin n_fail++; $display("FAIL reset_an got %b want 01", an); end
    n_checks++; if (seg !== 7'b0111111) begin n_fail++; $display("FAIL reset_seg got %b want 0111111", seg); end
    n_checks++; if (an_n !== 2'b10) begin n_fail++; $display("FAIL reset_an_n got %b want 10", an_n); end
    n_checks++; if (seg_n !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg_n got %b want 1000000", seg_n); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_count_up;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_no_wrap cyc %0d got %b want 0", i, wrap); end
      if (i == 3) begin
        n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL up_before_step got %h want 00", count); end
      end
      if (i == 4) begin
        n_checks++; if (count !== 8'h01) begin n_fail++; $display("FAIL up_first_step got %h want 01", count); end
      end
    end
    n_checks++; if (count !== 8'h10) begin n_fail++; $display("FAIL up_40_cycles got %h want 10", count); end
  endtask

  task automatic test_wrap_up;
    tick(356);
    n_checks++; if (count !== 8'h99) begin n_fail++; $display("FAIL preload_99 got %h want 99", count); end
    tick(3);
    n_checks++; if (count !== 8'h99 || wrap !== 1'b0) begin n_fail++; $display("FAIL pre_wrap got %h/%b want 99/0", count, wrap); end
    tick(1);
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL wrap_up_count got %h want 00", count); end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_up_pulse got %b want 1", wrap); end
    tick(1);
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_up_one_cycle got %b want 0", wrap); end
  endtask

  task automatic test_count_down;
    up = 1'b0;
    tick(2);
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL down_pre got %h want 00", count); end
    tick(1);
    n_checks++; if (count !== 8'h99 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_down got %h/%b want 99/1", count, wrap); end
    tick(1);
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_down_one_cycle got %b want 0", wrap); end
    tick(355);
    n_checks++; if (count !== 8'h10) begin n_fail++; $display("FAIL down_to_10 got %h want 10", count); end
    tick(4);
    n_checks++; if (count !== 8'h09 || wrap !== 1'b0) begin n_fail++; $display("FAIL borrow_10_09 got %h/%b want 09/0", count, wrap); end
  endtask

  task automatic test_short_press;
    up = 1'b1;
    clr = 1'b1; tick(1); clr = 1'b0;
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL clr_realign got %h want 00", count); end
    btn = 1'b1; tick(3); btn = 1'b0; tick(8);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL short_press got %b want 1", running); end
  endtask

  task automatic test_pause_resume;
    clr = 1'b1; tick(1); clr = 1'b0;
    tick(2);
    btn = 1'b1;
    tick(7);
    n_checks++; if (running !== 1'b1 || count !== 8'h02) begin n_fail++; $display("FAIL pre_pause got %b/%h want 1/02", running, count); end
    tick(1);
    n_checks++; if (running !== 1'b0 || count !== 8'h02) begin n_fail++; $display("FAIL pause_at_8 got %b/%h want 0/02", running, count); end
    tick(4); btn = 1'b0;
    tick(20);
    n_checks++; if (running !== 1'b0 || count !== 8'h02) begin n_fail++; $display("FAIL frozen got %b/%h want 0/02", running, count); end
    btn = 1'b1;
    tick(7);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL resume_early got %b want 0", running); end
    tick(1);
    n_checks++; if (running !== 1'b1 || count !== 8'h02) begin n_fail++; $display("FAIL resume got %b/%h want 1/02", running, count); end
    tick(1);
    n_checks++; if (count !== 8'h02) begin n_fail++; $display("FAIL phase_kept_hold got %h want 02", count); end
    tick(1);
    n_checks++; if (count !== 8'h03) begin n_fail++; $display("FAIL phase_kept_step got %h want 03", count); end
    btn = 1'b0;
    tick(10);
  endtask

  task automatic test_clr_priority;
    tick(1);
    n_checks++; if (count !== 8'h05) begin n_fail++; $display("FAIL pre_clr got %h want 05", count); end
    clr = 1'b1; tick(1); clr = 1'b0;
    n_checks++; if (count !== 8'h00 || wrap !== 1'b0) begin n_fail++; $display("FAIL clr_step got %h/%b want 00/0", count, wrap); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL clr_running got %b want 1", running); end
    tick(3);
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL clr_presc_hold got %h want 00", count); end
    tick(1);
    n_checks++; if (count !== 8'h01) begin n_fail++; $display("FAIL clr_presc_step got %h want 01", count); end
  endtask

  task automatic test_reset_mid_count;
    tick(2);
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("FAIL async_rst_count got %h want 00", count); end
    n_checks++; if (an !== 2'b01 || seg !== 7'b0111111) begin n_fail++; $display("FAIL async_rst_disp got %b/%b want 01/0111111", an, seg); end
    n_checks++; if (an_n !== 2'b10 || seg_n !== 7'b1000000) begin n_fail++; $display("FAIL async_rst_disp_n got %b/%b want 10/1000000", an_n, seg_n); end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_scan;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    up = 1'b1;
    tick(160);
    n_checks++; if (count !== 8'h40) begin n_fail++; $display("FAIL scan_pre_40 got %h want 40", count); end
    btn = 1'b1;
    tick(7);
    n_checks++; if (count !== 8'h41 || running !== 1'b1) begin n_fail++; $display("FAIL scan_pre_41 got %h/%b want 41/1", count, running); end
    tick(1);
    n_checks++; if (count !== 8'h42 || running !== 1'b0) begin n_fail++; $display("FAIL toggle_with_step got %h/%b want 42/0", count, running); end
    tick(4); btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      exp_an  = (((cyc - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01;
      exp_seg = (exp_an == 2'b01) ? 7'b1011011 : 7'b1100110;
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an cyc %0d got %b want %b", cyc, an, exp_an); end
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg cyc %0d got %b want %b", cyc, seg, exp_seg); end
      n_checks++; if (an_n !== ~exp_an) begin n_fail++; $display("FAIL scan_an_n cyc %0d got %b want %b", cyc, an_n, ~exp_an); end
      n_checks++; if (seg_n !== ~exp_seg) begin n_fail++; $display("FAIL scan_seg_n cyc %0d got %b want %b", cyc, seg_n, ~exp_seg); end
    end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_wrap_up;
    test_count_down;
    test_short_press;
    test_pause_resume;
    test_clr_priority;
    test_reset_mid_count;
    test_scan;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
